// File: rtl/sobel_pkg.sv
// Shared defaults and FSM state encoding for the Sobel window sequencer slice.
package sobel_pkg;

  localparam int DATA_SIZE_DEF = 24;
  localparam int OUT_SIZE_DEF  = DATA_SIZE_DEF + 5;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_GX   = 2'd1,
    S_GY   = 2'd2,
    S_CAP  = 2'd3
  } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of storage: one write and one asynchronous read per cycle at the
// same address, so the read returns the value from the previous line (read-before-write).
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; every location is written before a valid window reads it.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/sobel_window_sequencer.sv
// Builds a 3x3 raster window from two line buffers and time-shares one external conv
// between Gx and Gy, returning the signed (Gx,Gy) pair with valid/ready flow control.
module sobel_window_sequencer
  import sobel_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int OUT_SIZE   = OUT_SIZE_DEF,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_SIZE-1:0]       pix_in,
  input  logic                       pix_sof,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [DATA_SIZE-1:0]       conv_p1a,
  output logic [DATA_SIZE-1:0]       conv_p2,
  output logic [DATA_SIZE-1:0]       conv_p1b,
  output logic [DATA_SIZE-1:0]       conv_m1a,
  output logic [DATA_SIZE-1:0]       conv_m2,
  output logic [DATA_SIZE-1:0]       conv_m1b,
  input  logic signed [OUT_SIZE-1:0] conv_result,
  output logic signed [OUT_SIZE-1:0] grad_gx,
  output logic signed [OUT_SIZE-1:0] grad_gy,
  output logic                       grad_last,
  output logic                       grad_valid,
  input  logic                       grad_ready
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_t                     state;
  logic [CW-1:0]              col;
  logic [RW-1:0]              row;
  logic [DATA_SIZE-1:0]       win [3][3];
  logic [DATA_SIZE-1:0]       lb0_rd, lb1_rd;
  logic signed [OUT_SIZE-1:0] gx_tmp;
  logic                       pend_last;

  logic          accept, win_ok, at_last;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  // A pixel flagged pix_sof is pixel (0,0) no matter where the counters were.
  assign accept  = pix_valid && pix_ready;
  assign cur_col = pix_sof ? '0 : col;
  assign cur_row = pix_sof ? '0 : row;
  assign win_ok  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign at_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Line 1 holds the previous row; line 0 takes what line 1 held (two rows back).
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_SIZE)) u_line_prev (
    .clk     (clk),
    .we      (accept),
    .addr    (cur_col),
    .wr_data (pix_in),
    .rd_data (lb1_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_SIZE)) u_line_oldest (
    .clk     (clk),
    .we      (accept),
    .addr    (cur_col),
    .wr_data (lb1_rd),
    .rd_data (lb0_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FILL;
      col        <= '0;
      row        <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
      conv_p1a   <= '0;
      conv_p2    <= '0;
      conv_p1b   <= '0;
      conv_m1a   <= '0;
      conv_m2    <= '0;
      conv_m1b   <= '0;
      gx_tmp     <= '0;
      pend_last  <= 1'b0;
      grad_gx    <= '0;
      grad_gy    <= '0;
      grad_last  <= 1'b0;
      grad_valid <= 1'b0;
      pix_ready  <= 1'b0;
    end else begin
      // NOTE: later non-blocking assignments in this block override earlier defaults.
      if (grad_valid && grad_ready) grad_valid <= 1'b0;

      unique case (state)
        S_FILL: begin
          pix_ready <= 1'b1;
          if (accept) begin
            for (int r = 0; r < 3; r++) begin
              win[r][0] <= win[r][1];
              win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= pix_in;

            if (cur_col == COL_LAST) begin
              col <= '0;
              row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
              col <= cur_col + 1'b1;
              row <= cur_row;
            end

            if (win_ok) begin
              // Gx taps come from the post-shift window so they are live during S_GX.
              conv_p1a  <= lb0_rd;
              conv_p2   <= lb1_rd;
              conv_p1b  <= pix_in;
              conv_m1a  <= win[0][1];
              conv_m2   <= win[1][1];
              conv_m1b  <= win[2][1];
              pend_last <= at_last;
              pix_ready <= 1'b0;
              state     <= S_GX;
            end
          end
        end
        S_GX: begin
          conv_p1a <= win[0][0];
          conv_p2  <= win[0][1];
          conv_p1b <= win[0][2];
          conv_m1a <= win[2][0];
          conv_m2  <= win[2][1];
          conv_m1b <= win[2][2];
          state    <= S_GY;
        end
        S_GY: begin
          gx_tmp <= conv_result;
          state  <= S_CAP;
        end
        S_CAP: begin
          if (!grad_valid || grad_ready) begin
            grad_gx    <= gx_tmp;
            grad_gy    <= conv_result;
            grad_last  <= pend_last;
            grad_valid <= 1'b1;
            pix_ready  <= 1'b1;
            state      <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Directed bench for sobel_window_sequencer on an 8x6 image with a behavioural conv.
module tb_sobel_window_sequencer;

  localparam int DS = 24;
  localparam int OS = 29;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int NW = (W - 2) * (H - 2);

  localparam int K_CONST = 0, K_HRAMP = 1, K_VRAMP = 2, K_SPOT = 3, K_EDGE = 4, K_RAND = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DS-1:0]        pix_in;
  logic                 pix_sof, pix_valid, pix_ready;
  logic [DS-1:0]        conv_p1a, conv_p2, conv_p1b, conv_m1a, conv_m2, conv_m1b;
  logic signed [OS-1:0] conv_result;
  logic signed [OS-1:0] grad_gx, grad_gy;
  logic                 grad_last, grad_valid, grad_ready;

  int n_tests = 0;
  int n_fail  = 0;

  sobel_window_sequencer #(.DATA_SIZE(DS), .OUT_SIZE(OS), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_sof     (pix_sof),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .conv_p1a    (conv_p1a),
    .conv_p2     (conv_p2),
    .conv_p1b    (conv_p1b),
    .conv_m1a    (conv_m1a),
    .conv_m2     (conv_m2),
    .conv_m1b    (conv_m1b),
    .conv_result (conv_result),
    .grad_gx     (grad_gx),
    .grad_gy     (grad_gy),
    .grad_last   (grad_last),
    .grad_valid  (grad_valid),
    .grad_ready  (grad_ready)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for sobel_matrix_conv: one registered stage.
  always_ff @(posedge clk) begin
    conv_result <= OS'(longint'(conv_p1a) + 2 * longint'(conv_p2) + longint'(conv_p1b)
                     - longint'(conv_m1a) - 2 * longint'(conv_m2) - longint'(conv_m1b));
  end

  logic [DS-1:0] img [H][W];
  longint        e_gx [NW];
  longint        e_gy [NW];

  // Output monitor: records every handshake and counts hold-stability violations.
  logic                 mon_en = 1'b0;
  int                   got_n, hold_err;
  logic signed [OS-1:0] got_gx [32];
  logic signed [OS-1:0] got_gy [32];
  logic                 got_last [32];
  logic                 hold_v, hold_last;
  logic signed [OS-1:0] hold_gx, hold_gy;

  always @(negedge clk) begin
    if (!mon_en) begin
      got_n    <= 0;
      hold_err <= 0;
      hold_v   <= 1'b0;
    end else begin
      if (hold_v && (!grad_valid || grad_gx != hold_gx || grad_gy != hold_gy ||
                     grad_last != hold_last))
        hold_err <= hold_err + 1;
      hold_v    <= grad_valid && !grad_ready;
      hold_gx   <= grad_gx;
      hold_gy   <= grad_gy;
      hold_last <= grad_last;
      if (grad_valid && grad_ready) begin
        if (got_n < 32) begin
          got_gx[got_n]   <= grad_gx;
          got_gy[got_n]   <= grad_gy;
          got_last[got_n] <= grad_last;
        end
        got_n <= got_n + 1;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_img(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (kind)
          K_CONST: img[r][c] = 24'h000005;
          K_HRAMP: img[r][c] = DS'(c);
          K_VRAMP: img[r][c] = DS'(r);
          K_EDGE:  img[r][c] = (c == 0) ? 24'hFFFFFF : 24'h0;
          K_RAND:  img[r][c] = DS'($urandom);
          default: img[r][c] = '0;
        endcase
      end
    if (kind == K_SPOT) begin
      img[0][0] = 24'd10; img[1][0] = 24'd0; img[2][0] = 24'd5;
      img[0][2] = 24'd9;  img[1][2] = 24'd6; img[2][2] = 24'd8;
    end
    // Reference Sobel over every interior window, raster order.
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        automatic int k = (r - 2) * (W - 2) + (c - 2);
        e_gx[k] = longint'(img[r-2][c]) + 2 * longint'(img[r-1][c]) + longint'(img[r][c])
                - longint'(img[r-2][c-2]) - 2 * longint'(img[r-1][c-2]) - longint'(img[r][c-2]);
        e_gy[k] = longint'(img[r-2][c-2]) + 2 * longint'(img[r-2][c-1]) + longint'(img[r-2][c])
                - longint'(img[r][c-2]) - 2 * longint'(img[r][c-1]) - longint'(img[r][c]);
      end
  endtask

  // Called just after a rising edge; presents n raster pixels, sof on the first.
  task automatic send_pixels(input int n);
    logic rdy;
    for (int p = 0; p < n; p++) begin
      automatic int budget = 0;
      pix_in    = img[p / W][p % W];
      pix_sof   = (p == 0);
      pix_valid = 1'b1;
      do begin
        @(negedge clk) rdy = pix_ready;
        @(posedge clk) #1;
        budget++;
      end while (!rdy && budget < 100);
      if (!rdy) check($sformatf("pix_ready_timeout[%0d]", p), rdy, 1);
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic restart_monitor();
    mon_en = 1'b0;
    @(posedge clk) #1;
    mon_en = 1'b1;
  endtask

  task automatic drain_and_check(input string tag);
    automatic int w = 0;
    while (got_n < NW && w < 300) begin
      @(posedge clk) #1;
      w++;
    end
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_pairs"}, got_n, NW);
    for (int i = 0; i < NW && i < got_n; i++) begin
      check($sformatf("%s_gx[%0d]", tag, i), got_gx[i], e_gx[i]);
      check($sformatf("%s_gy[%0d]", tag, i), got_gy[i], e_gy[i]);
      check($sformatf("%s_last[%0d]", tag, i), got_last[i], (i == NW - 1) ? 1 : 0);
    end
    check({tag, "_hold_stable"}, hold_err, 0);
  endtask

  typedef struct {
    string  name;
    int     kind;
    bit     has_first;
    longint first_gx;
    longint first_gy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"const",  K_CONST, 1'b1, 0,         0};
    vecs[1] = '{"hramp",  K_HRAMP, 1'b1, 8,         0};
    vecs[2] = '{"vramp",  K_VRAMP, 1'b1, 0,         -8};
    vecs[3] = '{"spot",   K_SPOT,  1'b1, 14,        6};
    vecs[4] = '{"edge",   K_EDGE,  1'b1, -67108860, 0};
    vecs[5] = '{"random", K_RAND,  1'b0, 0,         0};

    rst        = 1'b1;
    pix_in     = '0;
    pix_sof    = 1'b0;
    pix_valid  = 1'b0;
    grad_ready = 1'b1;
    #1;
    check("reset_pix_ready", pix_ready, 0);
    check("reset_grad_valid", grad_valid, 0);
    check("reset_conv_p1a", conv_p1a, 0);
    check("reset_grad_gx", grad_gx, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk) #1;
    check("ready_after_reset", pix_ready, 1);

    // Whole frames with hand-derived first pairs plus the reference model.
    for (int v = 0; v < 6; v++) begin
      fill_img(vecs[v].kind);
      restart_monitor();
      send_pixels(W * H);
      drain_and_check(vecs[v].name);
      if (vecs[v].has_first && got_n > 0) begin
        check({vecs[v].name, "_first_gx"}, got_gx[0], vecs[v].first_gx);
        check({vecs[v].name, "_first_gy"}, got_gy[0], vecs[v].first_gy);
      end
    end

    // Downstream stall on the first pair of a frame.
    fill_img(K_RAND);
    restart_monitor();
    grad_ready = 1'b0;
    fork
      send_pixels(W * H);
      begin
        automatic int w = 0;
        while (!grad_valid && w < 200) begin
          @(negedge clk);
          w++;
        end
        check("stall_first_valid", grad_valid, 1);
        repeat (10) @(negedge clk);
        check("stall_pix_ready", pix_ready, 0);
        check("stall_held_valid", grad_valid, 1);
        check("stall_held_gx", grad_gx, e_gx[0]);
        check("stall_held_gy", grad_gy, e_gy[0]);
        @(posedge clk) #1;
        grad_ready = 1'b1;
      end
    join
    drain_and_check("stall");

    // Mid-frame resync: pix_sof arrives while counters sit at row 2, col 5.
    fill_img(K_HRAMP);
    mon_en = 1'b0;
    send_pixels(21);
    repeat (10) @(posedge clk);
    #1;
    fill_img(K_RAND);
    restart_monitor();
    send_pixels(W * H);
    drain_and_check("resync");

    // Reset right after a valid window was accepted, then a clean frame.
    fill_img(K_VRAMP);
    mon_en = 1'b0;
    send_pixels(30);
    rst = 1'b1;
    #1;
    check("midrst_grad_valid", grad_valid, 0);
    check("midrst_pix_ready", pix_ready, 0);
    check("midrst_conv_p1b", conv_p1b, 0);
    check("midrst_grad_gy", grad_gy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk) #1;
    check("midrst_ready_after", pix_ready, 1);
    check("midrst_valid_after", grad_valid, 0);
    fill_img(K_RAND);
    restart_monitor();
    send_pixels(W * H);
    drain_and_check("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
